// File: rtl/rv32imc_types.sv
// Shared types for the execute-stage M-extension sequencer.
// Holds the sequencer state encoding, the unit selector and the divide-by-zero quotient.
package rv32imc_types;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WAIT_OPND,
        SEQ_START,
        SEQ_BUSY,
        SEQ_DONE,
        SEQ_DRAIN
    } muldiv_seq_state_t;

    typedef enum logic {
        mul_unit = 1'b0,
        div_unit = 1'b1
    } muldiv_unit_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_watchdog.sv
// Counts consecutive cycles while the sequencer waits on a unit and raises a sticky
// timeout once TIMEOUT_CYCLES have elapsed without the unit finishing.
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expire,
    output logic timeout
);

    logic [CNT_W-1:0] count;

    assign expire = active && (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            // Restart on expiry so a flush racing the timeout still bounds the drain.
            count   <= (active && !expire) ? count + CNT_W'(1) : '0;
            timeout <= timeout | expire;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage controller for the shared iterative multiplier/divider.
// Optional macro MULDIV_ZERO_BYPASS_EN: resolve zero-operand ops without starting a unit.
module muldiv_sequencer
    import rv32imc_types::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_unit,
    input  logic        i_rem,
    input  logic        i_signed,
    input  logic        i_opnd_wait,
    input  logic        i_advance,
    input  logic        i_flush,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_mul_busy,
    input  logic        i_div_busy,
    input  logic [31:0] i_mul_fout,
    input  logic [31:0] i_div_fout,
    output logic        o_mul_start,
    output logic        o_div_start,
    output logic        o_func_stall,
    output logic [31:0] o_result,
    output logic        o_result_valid,
    output logic        o_timeout
);

    muldiv_seq_state_t state, state_next;
    muldiv_unit_t      unit_q, unit_sel;
    logic              state_entry;
    logic              sel_busy;
    logic [31:0]       sel_fout;
    logic              bypass_hit;
    logic [31:0]       bypass_val;
    logic              result_load;
    logic [31:0]       result_next;
    logic              wd_active, wd_expire;
    logic              unused_inputs;

    // The op's unit is only trusted from ID/EX until it has been launched.
    assign unit_sel = (state == SEQ_IDLE || state == SEQ_WAIT_OPND) ? muldiv_unit_t'(i_unit) : unit_q;
    assign sel_busy = (unit_sel == div_unit) ? i_div_busy : i_mul_busy;
    assign sel_fout = (unit_sel == div_unit) ? i_div_fout : i_mul_fout;

`ifdef MULDIV_ZERO_BYPASS_EN
    always_comb begin
        bypass_hit = 1'b0;
        bypass_val = '0;
        if (unit_sel == mul_unit) begin
            bypass_hit = (i_a == '0) || (i_b == '0);
        end else if (i_b == '0) begin
            bypass_hit = 1'b1;
            bypass_val = i_rem ? i_a : DIV_BY_ZERO_Q;
        end
    end
    assign unused_inputs = i_signed;
`else
    assign bypass_hit    = 1'b0;
    assign bypass_val    = '0;
    assign unused_inputs = ^{i_rem, i_signed};
`endif

    assign wd_active      = (state == SEQ_BUSY) || (state == SEQ_DRAIN);
    assign o_result_valid = (state == SEQ_DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        o_func_stall = 1'b0;
        result_load  = 1'b0;
        result_next  = o_result;
        case (state)
            SEQ_IDLE, SEQ_WAIT_OPND: begin
                o_func_stall = (state == SEQ_WAIT_OPND) || i_valid;
                if (i_flush) begin
                    state_next = SEQ_IDLE;
                end else if (state == SEQ_WAIT_OPND || i_valid) begin
                    if (i_opnd_wait) begin
                        state_next = SEQ_WAIT_OPND;
                    end else if (bypass_hit) begin
                        state_next  = SEQ_DONE;
                        result_load = 1'b1;
                        result_next = bypass_val;
                    end else begin
                        state_next = SEQ_START;
                    end
                end
            end
            SEQ_START: begin
                o_func_stall = 1'b1;
                state_next   = i_flush ? SEQ_DRAIN : SEQ_BUSY;
            end
            SEQ_BUSY: begin
                o_func_stall = 1'b1;
                if (i_flush) begin
                    state_next = SEQ_DRAIN;
                end else if (wd_expire) begin
                    state_next  = SEQ_DONE;
                    result_load = 1'b1;
                    result_next = '0;
                end else if (!state_entry && !sel_busy) begin
                    state_next  = SEQ_DONE;
                    result_load = 1'b1;
                    result_next = sel_fout;
                end
            end
            SEQ_DONE: begin
                if (i_flush || i_advance) state_next = SEQ_IDLE;
            end
            SEQ_DRAIN: begin
                o_func_stall = i_valid;
                if (wd_expire || (!state_entry && !sel_busy)) state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= SEQ_IDLE;
            unit_q      <= mul_unit;
            state_entry <= 1'b0;
            o_mul_start <= 1'b0;
            o_div_start <= 1'b0;
            o_result    <= '0;
        end else begin
            state       <= state_next;
            unit_q      <= unit_sel;
            // Units raise busy a cycle late, so the first BUSY/DRAIN cycle ignores it.
            state_entry <= (state_next != state);
            o_mul_start <= (state_next == SEQ_START) && (unit_sel == mul_unit);
            o_div_start <= (state_next == SEQ_START) && (unit_sel == div_unit);
            if (result_load) o_result <= result_next;
        end
    end

    muldiv_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (wd_active),
        .expire (wd_expire),
        .timeout(o_timeout)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer with behavioural mul/div units
// and an op-level reference (latency, strobe count, result) derived from plain arithmetic.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_unit, i_rem, i_signed, i_opnd_wait, i_advance, i_flush;
    logic [31:0] i_a, i_b;
    logic        i_mul_busy, i_div_busy;
    logic [31:0] i_mul_fout, i_div_fout;
    logic        o_mul_start, o_div_start, o_func_stall, o_result_valid, o_timeout;
    logic [31:0] o_result;

    int total = 0;
    int bad   = 0;

    int          mul_lat = 1, div_lat = 1;
    logic        div_stuck = 1'b0;
    int          mul_left, div_left;
    logic [31:0] mul_res, div_res;
    int          overlap = 0;

    localparam int TIMEOUT = 64;

    muldiv_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (i_valid),
        .i_unit        (i_unit),
        .i_rem         (i_rem),
        .i_signed      (i_signed),
        .i_opnd_wait   (i_opnd_wait),
        .i_advance     (i_advance),
        .i_flush       (i_flush),
        .i_a           (i_a),
        .i_b           (i_b),
        .i_mul_busy    (i_mul_busy),
        .i_div_busy    (i_div_busy),
        .i_mul_fout    (i_mul_fout),
        .i_div_fout    (i_div_fout),
        .o_mul_start   (o_mul_start),
        .o_div_start   (o_div_start),
        .o_func_stall  (o_func_stall),
        .o_result      (o_result),
        .o_result_valid(o_result_valid),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic unit, input logic rem,
                                               input logic [31:0] a, input logic [31:0] b);
        if (!unit) return a * b;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        return rem ? a % b : a / b;
    endfunction

    // Behavioural units: capture operands on the start strobe, busy for *_lat cycles after it.
    always @(posedge clk) begin
        if (!rst) begin
            mul_left <= 0;
            div_left <= 0;
            mul_res  <= '0;
            div_res  <= '0;
        end else begin
            if (o_mul_start) begin
                mul_left <= mul_lat;
                mul_res  <= ref_result(1'b0, 1'b0, i_a, i_b);
            end else if (mul_left > 0) begin
                mul_left <= mul_left - 1;
            end
            if (o_div_start) begin
                div_left <= div_lat;
                div_res  <= ref_result(1'b1, i_rem, i_a, i_b);
            end else if (div_left > 0) begin
                div_left <= div_left - 1;
            end
            if ((o_mul_start && i_div_busy) || (o_div_start && i_mul_busy)) overlap <= overlap + 1;
        end
    end

    assign i_mul_busy = (mul_left != 0);
    assign i_div_busy = div_stuck || (div_left != 0);
    assign i_mul_fout = mul_res;
    assign i_div_fout = div_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic unit, input logic rem, input logic wt,
                         input logic adv, input logic fl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        i_valid     = valid;
        i_unit      = unit;
        i_rem       = rem;
        i_opnd_wait = wt;
        i_advance   = adv;
        i_flush     = fl;
        i_a         = a;
        i_b         = b;
        #1;
    endtask

    // Presents one op from its first valid cycle until the sequencer reports a held result.
    task automatic issue(input logic unit, input logic rem, input logic [31:0] a, input logic [31:0] b,
                         input int w, output int done_cyc, output int stalls, output int ms,
                         output int ds, output int start_cyc);
        logic seen;
        seen      = 1'b0;
        done_cyc  = -1;
        stalls    = 0;
        ms        = 0;
        ds        = 0;
        start_cyc = -1;
        i_signed  = 1'($urandom);
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            if (cyc < w) drive(1'b1, unit, rem, 1'b1, 1'b0, 1'b0, $urandom, $urandom);
            else         drive(1'b1, unit, rem, 1'b0, 1'b0, 1'b0, a, b);
            if (cyc == 0) check("rv_clear_at_issue", 32'(o_result_valid), 32'd0);
            if (o_result_valid) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end else begin
                stalls += int'(o_func_stall);
                ms     += int'(o_mul_start);
                ds     += int'(o_div_start);
                if (o_mul_start || o_div_start) start_cyc = cyc;
            end
        end
        if (!seen) check("done_bound", 32'd0, 32'd1);
    endtask

    task automatic hold_done(input logic [31:0] exp, input int hold);
        for (int i = 0; i < hold; i++) begin
            drive(1'b1, i_unit, i_rem, 1'b0, 1'b0, 1'b0, i_a, i_b);
            check("hold_result", o_result, exp);
            check("hold_stall", 32'(o_func_stall), 32'd0);
            check("hold_valid", 32'(o_result_valid), 32'd1);
        end
        drive(1'b1, i_unit, i_rem, 1'b0, 1'b1, 1'b0, i_a, i_b);
        check("advance_valid", 32'(o_result_valid), 32'd1);
    endtask

    task automatic run_op(input logic unit, input logic rem, input logic [31:0] a, input logic [31:0] b,
                          input int w, input int lat, input int hold);
        int          done_cyc, stalls, ms, ds, sc, exp_done;
        logic        bypass;
        logic [31:0] exp;
        exp    = ref_result(unit, rem, a, b);
        bypass = 1'b0;
`ifdef MULDIV_ZERO_BYPASS_EN
        bypass = unit ? (b == 32'd0) : (a == 32'd0 || b == 32'd0);
`endif
        if (unit) div_lat = lat;
        else      mul_lat = lat;
        exp_done = bypass ? w + 1 : w + 3 + lat;
        issue(unit, rem, a, b, w, done_cyc, stalls, ms, ds, sc);
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("stall_cycles", 32'(stalls), 32'(exp_done));
        check("mul_starts", 32'(ms), (!bypass && !unit) ? 32'd1 : 32'd0);
        check("div_starts", 32'(ds), (!bypass && unit) ? 32'd1 : 32'd0);
        check("start_cycle", 32'(sc), bypass ? 32'hFFFF_FFFF : 32'(w + 1));
        check("result", o_result, exp);
        check("done_stall", 32'(o_func_stall), 32'd0);
        hold_done(exp, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          done_cyc, stalls, ms, ds, sc;
        logic [31:0] ra, rb;

        // Reset with a pending op on the inputs: reset must dominate.
        rst = 1'b0;
        i_signed = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd3);
        check("rst_mul_start", 32'(o_mul_start), 32'd0);
        check("rst_div_start", 32'(o_div_start), 32'd0);
        check("rst_result_valid", 32'(o_result_valid), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        check("rst_result", o_result, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("idle_stall", 32'(o_func_stall), 32'd0);

        // Directed: mul busy 4, div with 3 wait cycles and a 5-cycle hold.
        run_op(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678, 0, 4, 0);
        run_op(1'b1, 1'b0, 32'd1000, 32'd7, 3, 5, 5);
        run_op(1'b1, 1'b1, 32'd1000, 32'd7, 1, 2, 1);

        // Zero-operand corner cases: divu/remu by zero and mul by zero.
        run_op(1'b1, 1'b0, 32'd7, 32'd0, 0, 4, 1);
        run_op(1'b1, 1'b1, 32'd7, 32'd0, 0, 4, 1);
        run_op(1'b0, 1'b0, 32'd0, 32'd99, 2, 3, 0);

        for (int n = 0; n < 20; n++) begin
            ra = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 5000);
            run_op(1'($urandom), 1'($urandom), ra, rb, $urandom_range(0, 3),
                   $urandom_range(1, 8), $urandom_range(0, 3));
        end

        // Flush in BUSY while the divider still has 6 busy cycles left.
        div_lat = 8;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
        check("fl_stall_idle", 32'(o_func_stall), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
        check("fl_div_start", 32'(o_div_start), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1000, 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("fl_drain_no_valid_stall", 32'(o_func_stall), 32'd0);
        check("fl_drain_rv", 32'(o_result_valid), 32'd0);
        mul_lat = 3;
        issue(1'b0, 1'b0, 32'd11, 32'd13, 0, done_cyc, stalls, ms, ds, sc);
        check("fl_mul_starts", 32'(ms), 32'd1);
        check("fl_div_starts", 32'(ds), 32'd0);
        check("fl_start_after_busy", 32'(sc > 4), 32'd1);
        check("fl_mul_latency", 32'(done_cyc - sc), 32'd5);
        check("fl_mul_stalls", 32'(stalls), 32'(done_cyc));
        check("fl_mul_result", o_result, 32'd143);
        hold_done(32'd143, 0);

        // Flush while a result is held in DONE.
        mul_lat = 2;
        issue(1'b0, 1'b0, 32'd5, 32'd6, 0, done_cyc, stalls, ms, ds, sc);
        check("fd_result", o_result, 32'd30);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("fd_rv_cleared", 32'(o_result_valid), 32'd0);

        // Watchdog: divider never drops busy.
        check("to_flag_before", 32'(o_timeout), 32'd0);
        div_stuck = 1'b1;
        div_lat   = 2;
        issue(1'b1, 1'b0, 32'd100, 32'd7, 0, done_cyc, stalls, ms, ds, sc);
        check("to_done_cycle", 32'(done_cyc), 32'(TIMEOUT + 2));
        check("to_div_starts", 32'(ds), 32'd1);
        check("to_result", o_result, 32'd0);
        check("to_flag", 32'(o_timeout), 32'd1);
        hold_done(32'd0, 1);
        div_stuck = 1'b0;
        run_op(1'b0, 1'b0, 32'd9, 32'd9, 0, 2, 0);
        check("to_flag_sticky", 32'(o_timeout), 32'd1);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("to_flag_cleared", 32'(o_timeout), 32'd0);
        check("to_result_cleared", o_result, 32'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        check("unit_overlap", 32'(overlap), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
